// File: rtl/up_fifo_pkg.sv
// Shared constants for the upstream FIFO: default geometry, derived widths and reset values.
// No logic; pure compile-time constants.
// Imported by up_fifo and up_fifo_ram.
package up_fifo_pkg;

    localparam int UP_FIFO_ADDR_WIDTH       = 8;
    localparam int UP_FIFO_DATA_WIDTH       = 24;
    localparam int UP_FIFO_DEPTH            = 1 << UP_FIFO_ADDR_WIDTH;
    localparam int UP_FIFO_PTR_WIDTH        = UP_FIFO_ADDR_WIDTH + 1;
    localparam int UP_FIFO_OUT_REG          = 0;
    localparam int UP_FIFO_ALMOST_FULL_NUM  = 11;
    localparam int UP_FIFO_ALMOST_EMPTY_NUM = 4;

    // Flag values immediately after reset: an empty FIFO.
    localparam logic EMPTY_RST        = 1'b1;
    localparam logic ALMOST_EMPTY_RST = 1'b1;
    localparam logic FULL_RST         = 1'b0;
    localparam logic ALMOST_FULL_RST  = 1'b0;

endpackage

// File: rtl/up_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronously registered read port.
// Latency: read data valid one cycle after rd_en_i; write visible to reads on the next edge.
// No backpressure: the caller decides which requests are accepted.
module up_fifo_ram
    import up_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = UP_FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = UP_FIFO_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port: storage array has no reset, contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: register only updates on a read, so it holds between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/up_fifo.sv
// Single-clock standard-read FIFO with full/empty and programmable almost flags; optional water_level via UP_FIFO_WATER_LEVEL_EN.
// Latency: rd_data one cycle after an accepted read (two with OUT_REG=1); flags valid the cycle after the causing edge.
// Backpressure: writes while full and reads while empty are ignored; no same-cycle bypass.
module up_fifo
    import up_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = UP_FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH       = UP_FIFO_DATA_WIDTH,
    parameter int OUT_REG          = UP_FIFO_OUT_REG,
    parameter int ALMOST_FULL_NUM  = UP_FIFO_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = UP_FIFO_ALMOST_EMPTY_NUM
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
`ifdef UP_FIFO_WATER_LEVEL_EN
    output logic [ADDR_WIDTH:0]   water_level,
`endif
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(ALMOST_FULL_NUM);
    localparam logic [PTR_W-1:0] AE_LVL    = PTR_W'(ALMOST_EMPTY_NUM);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] occ_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Acceptance uses the registered flags, so a full FIFO never takes a write even with a read pending.
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    // Next pointers and flags derived from the next-state occupancy.
    always_comb begin
        wptr_d   = wptr_q + PTR_W'(wr_acc);
        rptr_d   = rptr_q + PTR_W'(rd_acc);
        occ_d    = wptr_d - rptr_d;
        full_d   = (occ_d == DEPTH_LVL);
        empty_d  = (occ_d == '0);
        afull_d  = (occ_d >= AF_LVL);
        aempty_d = (occ_d <= AE_LVL);
    end

    // Pointer and flag state.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            full_q   <= FULL_RST;
            empty_q  <= EMPTY_RST;
            afull_q  <= ALMOST_FULL_RST;
            aempty_q <= ALMOST_EMPTY_RST;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    up_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i     (wr_clk),
        .rst_i     (wr_rst),
        .wr_en_i   (wr_acc && !wr_rst),
        .wr_addr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rd_acc_q;
            logic [DATA_WIDTH-1:0] out_q;

            // Extra output stage loads only when the RAM register was just refreshed by a read.
            always_ff @(posedge wr_clk) begin
                if (wr_rst) begin
                    rd_acc_q <= 1'b0;
                    out_q    <= '0;
                end else begin
                    rd_acc_q <= rd_acc;
                    if (rd_acc_q) begin
                        out_q <= ram_rd_data;
                    end
                end
            end

            assign rd_data = out_q;
        end else begin : g_no_out_reg
            assign rd_data = ram_rd_data;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef UP_FIFO_WATER_LEVEL_EN
    assign water_level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_up_fifo.sv
module tb_up_fifo;

    logic        wr_clk = 1'b0;
    logic        wr_rst = 1'b1;
    logic        wr_en  = 1'b0;
    logic        rd_en  = 1'b0;
    logic [23:0] wr_data = '0;
    logic        full, almost_full, empty, almost_empty;
    logic [23:0] rd_data;
`ifdef UP_FIFO_WATER_LEVEL_EN
    logic [8:0]  water_level;
`endif

    always #5 wr_clk = ~wr_clk;

    up_fifo dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
`ifdef UP_FIFO_WATER_LEVEL_EN
        .water_level  (water_level),
`endif
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of stored words plus the last word read out.
    logic [23:0] mq[$];
    logic [23:0] m_rd = '0;

    typedef struct {
        bit          we;
        bit          re;
        logic [23:0] d;
        bit          e_empty;
        bit          e_aempty;
        logic [23:0] e_rd;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge: update the model from the inputs present at the edge, then compare.
    task automatic tick();
        bit wa, ra;
        @(posedge wr_clk);
        if (wr_rst) begin
            mq.delete();
            m_rd = '0;
        end else begin
            wa = wr_en && (mq.size() < 256);
            ra = rd_en && (mq.size() != 0);
            if (ra) m_rd = mq.pop_front();
            if (wa) mq.push_back(wr_data);
        end
        #1;
        chk("empty",        32'(empty),        32'(mq.size() == 0));
        chk("full",         32'(full),         32'(mq.size() == 256));
        chk("almost_full",  32'(almost_full),  32'(mq.size() >= 11));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 4));
        chk("rd_data",      32'(rd_data),      32'(m_rd));
`ifdef UP_FIFO_WATER_LEVEL_EN
        chk("water_level",  32'(water_level),  32'(mq.size()));
`endif
    endtask

    task automatic drive(input bit we, input bit re, input logic [23:0] d);
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        tick();
    endtask

    task automatic do_reset();
        wr_rst = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        tick();
        wr_rst = 1'b0;
    endtask

    initial begin
        // Hand-derived short sequence starting from an empty FIFO.
        tbl[0] = '{1'b1, 1'b0, 24'h111111, 1'b0, 1'b1, 24'h000000};
        tbl[1] = '{1'b1, 1'b0, 24'h222222, 1'b0, 1'b1, 24'h000000};
        tbl[2] = '{1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 24'h111111};
        tbl[3] = '{1'b1, 1'b1, 24'h333333, 1'b0, 1'b1, 24'h222222};
        tbl[4] = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 24'h333333};
        tbl[5] = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 24'h333333};
        tbl[6] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h333333};

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 24'h0);
        chk("idle_empty",   32'(empty),   32'd1);
        chk("idle_rd_data", 32'(rd_data), 32'd0);

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].we, tbl[i].re, tbl[i].d);
            chk("tbl_empty",  32'(empty),        32'(tbl[i].e_empty));
            chk("tbl_aempty", 32'(almost_empty), 32'(tbl[i].e_aempty));
            chk("tbl_full",   32'(full),         32'd0);
            chk("tbl_rd",     32'(rd_data),      32'(tbl[i].e_rd));
        end

        // Fill with 0..255, then one ignored write while full.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 24'(i));
            chk("fill_afull",  32'(almost_full),  32'(i + 1 >= 11));
            chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 4));
        end
        chk("fill_full", 32'(full), 32'd1);
        drive(1'b1, 1'b0, 24'd256);
        chk("over_full", 32'(full), 32'd1);

        // Drain in order, then reads while empty hold the last word.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 24'h0);
            chk("drain_seq", 32'(rd_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        drive(1'b0, 1'b1, 24'h0);
        drive(1'b0, 1'b1, 24'h0);
        chk("under_hold", 32'(rd_data), 32'd255);

        // Half full, then simultaneous read/write across pointer wrap.
        for (int i = 0; i < 128; i++) drive(1'b1, 1'b0, 24'(1000 + i));
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 24'(2000 + i));
            chk("steady_full",  32'(full),  32'd0);
            chk("steady_empty", 32'(empty), 32'd0);
        end

        // Reset mid-operation discards contents.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 24'(i + 7));
        do_reset();
        chk("rst_empty", 32'(empty),   32'd1);
        chk("rst_rd",    32'(rd_data), 32'd0);
        drive(1'b1, 1'b0, 24'hABCDEF);
        drive(1'b0, 1'b1, 24'h0);
        drive(1'b0, 1'b0, 24'h0);
        chk("post_rst_rd", 32'(rd_data), 32'hABCDEF);

        // Randomized traffic with phases biased toward filling and draining.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int pw;
            pw = ((i / 500) % 2 == 0) ? 85 : 25;
            drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (110 - pw),
                  24'($urandom));
        end

`ifdef UP_FIFO_WATER_LEVEL_EN
        begin
            int wl_exp[4];
            wl_exp = '{1, 2, 3, 2};
            do_reset();
            chk("wl_rst", 32'(water_level), 32'd0);
            for (int i = 0; i < 4; i++) begin
                drive(i < 3, i == 3, 24'(i));
                chk("wl_seq", 32'(water_level), 32'(wl_exp[i]));
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
